l2cache_control: RTL and testbench
==================================

Name: l2cache_control

Overview:
- Control FSM that sequences the two-way, 16-set L2 cache datapath.
- Takes line-sized (256-bit) read/write requests from the L1/arbiter side and issues tag-check, LRU, dirty, valid and data load strobes to the datapath.
- Runs writeback and fetch transactions on the physical-memory port.
- Keeps saturating hit, miss and writeback counters for performance debug.

Parameters:
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  upstream line read request, held until mem_resp
- mem_write  in  1  upstream line write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- hit  in  1  datapath tag match (either way, valid)
- dirty  in  1  datapath dirty bit of the LRU (victim) way
- pmem_resp  in  1  physical memory completion pulse
- pmem_read  out  1  physical memory line read request
- pmem_write  out  1  physical memory line write request
- pmem_addr_sel  out  1  0 = request address, 1 = victim {tag,set} address
- load_lru  out  1  update LRU for the current set
- load_tag  out  1  write tag into victim way
- load_data  out  1  write data into selected way
- load_valid  out  1  set valid of victim way
- data_in_sel  out  1  0 = pmem_rdata, 1 = mem_wdata
- set_dirty  out  1  set dirty bit of selected way
- clr_dirty  out  1  clear dirty bit of victim way
- stat_clr  in  1  synchronous clear of all counters
- hit_count  out  CNT_WIDTH  tag-check hits
- miss_count  out  CNT_WIDTH  tag-check misses
- wb_count  out  CNT_WIDTH  completed writebacks

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset:
  - State goes to IDLE.
  - All control outputs and mem_resp deassert in the same cycle they are decoded from IDLE.
  - All counters go to 0.
  - `rst` mid-transaction abandons the transaction: pmem_read/pmem_write drop the next cycle, and a pmem_resp arriving later is ignored.
- Output decoding: all control outputs are combinational from state plus inputs. Every output is 0 unless listed below.
- Request priority: mem_read and mem_write both high is treated as a write.
- IDLE:
  - mem_read|mem_write -> CHECK.
  - No outputs asserted.
- CHECK (address stable; hit and dirty valid this cycle):
  - Hit, read: mem_resp=1, load_lru=1; hit_count++ -> IDLE.
  - Hit, write: mem_resp=1, load_lru=1, load_data=1, data_in_sel=1, set_dirty=1; hit_count++ -> IDLE.
  - Miss with dirty=1: miss_count++ -> WRITEBACK.
  - Miss with dirty=0: miss_count++ -> FETCH.
- WRITEBACK:
  - Drives pmem_write=1, pmem_addr_sel=1 until pmem_resp.
  - On pmem_resp: wb_count++ -> FETCH.
- FETCH:
  - Drives pmem_read=1, pmem_addr_sel=0 until pmem_resp.
  - On pmem_resp (same cycle): load_data=1, data_in_sel=0, load_tag=1, load_valid=1, clr_dirty=1 -> CHECK.
  - The re-check then hits and completes the request. That re-check does not increment hit_count or miss_count; a refill flag distinguishes it.
- Latency:
  - Read hit: mem_resp in the 2nd cycle after the request is first seen (IDLE, then CHECK).
  - Clean miss: 2 cycles + memory latency + 1 (re-check).
  - Dirty miss: adds the writeback memory latency.
- Handshake:
  - pmem_read and pmem_write are never high together.
  - Each stays high continuously until pmem_resp.
  - Upstream must hold the request and address until mem_resp.
  - mem_resp is exactly one cycle per request.
- Counters:
  - Saturate at all-ones, with no wrap.
  - stat_clr wins over a simultaneous increment.
  - stat_clr does not affect the FSM.

Test Plan:
- Reset, then read miss on a clean set: FETCH with pmem_read=1 and pmem_addr_sel=0.
  - pmem_resp after 5 cycles -> fill strobes for 1 cycle, re-check, mem_resp 1 cycle later.
  - Result: miss_count=1, hit_count=0.
- Repeat the same address read -> mem_resp in cycle 2 with load_lru=1; hit_count=1, and no pmem activity.
- Write hit -> load_data=1, data_in_sel=1, set_dirty=1 and mem_resp in the same cycle.
- Then miss the same set with dirty=1:
  - WRITEBACK with pmem_write=1 and pmem_addr_sel=1 precedes FETCH.
  - Result: wb_count=1.
- Assert rst during FETCH at cycle 3 of a 10-cycle memory latency:
  - pmem_read=0 next cycle and state IDLE.
  - The late pmem_resp produces no strobes and no mem_resp.
- Preload counters to all-ones via 2^CNT_WIDTH hits (CNT_WIDTH=4: 16 hits), then one more hit -> hit_count stays 15.
  - stat_clr asserted together with a hit -> hit_count=0.
- Assert mem_read and mem_write together on a hit -> treated as a write, so set_dirty=1.

Source files
------------

// File: rtl/l2cache_control.sv
// Control FSM for the two-way, 16-set L2 cache: tag check, writeback and refill
// sequencing, plus saturating hit/miss/writeback statistics counters.
module l2cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic                 dirty,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 pmem_addr_sel,
    output logic                 load_lru,
    output logic                 load_tag,
    output logic                 load_data,
    output logic                 load_valid,
    output logic                 data_in_sel,
    output logic                 set_dirty,
    output logic                 clr_dirty,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FETCH     = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   refill_r;
    logic                   hit_inc_s;
    logic                   miss_inc_s;
    logic                   wb_inc_s;
    logic [CNT_WIDTH-1:0]   hit_count_r;
    logic [CNT_WIDTH-1:0]   miss_count_r;
    logic [CNT_WIDTH-1:0]   wb_count_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] one;
        one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (&value) begin
            return value;
        end else begin
            return value + one;
        end
    endfunction

    // State register and refill flag; the flag marks the re-check that follows a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            refill_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_FETCH) && pmem_resp) begin
                refill_r <= 1'b1;
            end else if (state_r == ST_CHECK) begin
                refill_r <= 1'b0;
            end else begin
                refill_r <= refill_r;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    next_state_s = ST_IDLE;
                end else if (dirty) begin
                    next_state_s = ST_WRITEBACK;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                if (pmem_resp) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_WRITEBACK;
                end
            end
            ST_FETCH: begin
                if (pmem_resp) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath strobes and counter increment requests; a write wins over a read.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        load_lru      = 1'b0;
        load_tag      = 1'b0;
        load_data     = 1'b0;
        load_valid    = 1'b0;
        data_in_sel   = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        hit_inc_s     = 1'b0;
        miss_inc_s    = 1'b0;
        wb_inc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_resp = 1'b0;
            end
            ST_CHECK: begin
                mem_resp    = hit;
                load_lru    = hit;
                load_data   = hit & mem_write;
                data_in_sel = hit & mem_write;
                set_dirty   = hit & mem_write;
                hit_inc_s   = hit & ~refill_r;
                miss_inc_s  = ~hit & ~refill_r;
            end
            ST_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                wb_inc_s      = pmem_resp;
            end
            ST_FETCH: begin
                pmem_read  = 1'b1;
                load_data  = pmem_resp;
                load_tag   = pmem_resp;
                load_valid = pmem_resp;
                clr_dirty  = pmem_resp;
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

    // Saturating statistics counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
            wb_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            hit_count_r  <= hit_inc_s  ? sat_inc(hit_count_r)  : hit_count_r;
            miss_count_r <= miss_inc_s ? sat_inc(miss_count_r) : miss_count_r;
            wb_count_r   <= wb_inc_s   ? sat_inc(wb_count_r)   : wb_count_r;
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;

endmodule

// File: tb/tb_l2cache_control.sv
// Table-driven bench for l2cache_control: each row is one clock cycle of inputs
// with the control outputs and counter values expected during that cycle.
module tb_l2cache_control;

    localparam int CW = 4;

    localparam logic [10:0] B_RESP = 11'b100_0000_0000;
    localparam logic [10:0] B_PR   = 11'b010_0000_0000;
    localparam logic [10:0] B_PW   = 11'b001_0000_0000;
    localparam logic [10:0] B_AS   = 11'b000_1000_0000;
    localparam logic [10:0] B_LRU  = 11'b000_0100_0000;
    localparam logic [10:0] B_TAG  = 11'b000_0010_0000;
    localparam logic [10:0] B_DAT  = 11'b000_0001_0000;
    localparam logic [10:0] B_VAL  = 11'b000_0000_1000;
    localparam logic [10:0] B_DIS  = 11'b000_0000_0100;
    localparam logic [10:0] B_SD   = 11'b000_0000_0010;
    localparam logic [10:0] B_CD   = 11'b000_0000_0001;
    localparam logic [10:0] NONE   = 11'b000_0000_0000;
    localparam logic [10:0] RHIT   = B_RESP | B_LRU;
    localparam logic [10:0] WHIT   = B_RESP | B_LRU | B_DAT | B_DIS | B_SD;
    localparam logic [10:0] FILL   = B_PR | B_DAT | B_TAG | B_VAL | B_CD;
    localparam logic [10:0] WB     = B_PW | B_AS;

    typedef struct {
        string       name;
        logic        rst;
        logic        rd;
        logic        wr;
        logic        hit;
        logic        dirty;
        logic        presp;
        logic        sclr;
        logic [10:0] exp;
        int          hc;
        int          mc;
        int          wc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, dirty = 1'b0;
    logic pmem_resp = 1'b0, stat_clr = 1'b0;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_lru, load_tag;
    logic load_data, load_valid, data_in_sel, set_dirty, clr_dirty;
    logic [CW-1:0] hit_count, miss_count, wb_count;
    logic [10:0] outs;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_lru, load_tag,
                   load_data, load_valid, data_in_sel, set_dirty, clr_dirty};

    l2cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
        .load_lru(load_lru), .load_tag(load_tag), .load_data(load_data),
        .load_valid(load_valid), .data_in_sel(data_in_sel), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .stat_clr(stat_clr), .hit_count(hit_count),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    task automatic add(input string name, input logic r, input logic rd, input logic wr,
                       input logic h, input logic d, input logic pr, input logic sc,
                       input logic [10:0] exp, input int hc, input int mc, input int wc);
        vec_t v;
        v.name = name; v.rst = r; v.rd = rd; v.wr = wr; v.hit = h; v.dirty = d;
        v.presp = pr; v.sclr = sc; v.exp = exp; v.hc = hc; v.mc = mc; v.wc = wc;
        vq.push_back(v);
    endtask

    task automatic check_cnt(input string name, input string which,
                             input logic [CW-1:0] got, input int want);
        n_checks++;
        if (got !== want[CW-1:0]) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", name, which, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; mem_read = v.rd; mem_write = v.wr; hit = v.hit;
        dirty = v.dirty; pmem_resp = v.presp; stat_clr = v.sclr;
        #1;
        n_checks++;
        if (outs !== v.exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %b expected %b", v.name, outs, v.exp);
        end
        if ((pmem_read === 1'b1) && (pmem_write === 1'b1)) begin
            n_fail++;
            $display("FAIL %s pmem_rw_exclusive: got both high expected at most one", v.name);
        end
        check_cnt(v.name, "hit_count", hit_count, v.hc);
        check_cnt(v.name, "miss_count", miss_count, v.mc);
        check_cnt(v.name, "wb_count", wb_count, v.wc);
    endtask

    initial begin
        //   name            rst rd wr hit drt prsp clr  exp   hc mc wc
        add("reset_idle",    0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        // Clean read miss, memory answers after 5 fetch cycles.
        add("rm_idle",       0, 1, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        add("rm_check",      0, 1, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add("rm_fetch",  0, 1, 0, 0, 0, 0, 0, B_PR, 0, 1, 0);
        add("rm_fill",       0, 1, 0, 0, 0, 1, 0, FILL, 0, 1, 0);
        add("rm_recheck",    0, 1, 0, 1, 0, 0, 0, RHIT, 0, 1, 0);
        add("rm_done",       0, 0, 0, 0, 0, 0, 0, NONE, 0, 1, 0);
        // Read hit on the same line.
        add("rh_idle",       0, 1, 0, 0, 0, 0, 0, NONE, 0, 1, 0);
        add("rh_check",      0, 1, 0, 1, 0, 0, 0, RHIT, 0, 1, 0);
        add("rh_done",       0, 0, 0, 0, 0, 0, 0, NONE, 1, 1, 0);
        // Write hit.
        add("wh_idle",       0, 0, 1, 0, 0, 0, 0, NONE, 1, 1, 0);
        add("wh_check",      0, 0, 1, 1, 0, 0, 0, WHIT, 1, 1, 0);
        add("wh_done",       0, 0, 0, 0, 0, 0, 0, NONE, 2, 1, 0);
        // Dirty miss: writeback then fetch.
        add("dm_idle",       0, 1, 0, 0, 0, 0, 0, NONE, 2, 1, 0);
        add("dm_check",      0, 1, 0, 0, 1, 0, 0, NONE, 2, 1, 0);
        add("dm_wb",         0, 1, 0, 0, 1, 0, 0, WB,   2, 2, 0);
        add("dm_wb",         0, 1, 0, 0, 1, 0, 0, WB,   2, 2, 0);
        add("dm_wb_resp",    0, 1, 0, 0, 1, 1, 0, WB,   2, 2, 0);
        add("dm_fetch",      0, 1, 0, 0, 0, 0, 0, B_PR, 2, 2, 1);
        add("dm_fill",       0, 1, 0, 0, 0, 1, 0, FILL, 2, 2, 1);
        add("dm_recheck",    0, 1, 0, 1, 0, 0, 0, RHIT, 2, 2, 1);
        add("dm_done",       0, 0, 0, 0, 0, 0, 0, NONE, 2, 2, 1);
        // Read and write together on a hit behave as a write.
        add("rw_idle",       0, 1, 1, 0, 0, 0, 0, NONE, 2, 2, 1);
        add("rw_check",      0, 1, 1, 1, 0, 0, 0, WHIT, 2, 2, 1);
        add("rw_done",       0, 0, 0, 0, 0, 0, 0, NONE, 3, 2, 1);
        // Reset in the third cycle of a 10-cycle fetch; the late response is ignored.
        add("rst_idle",      0, 1, 0, 0, 0, 0, 0, NONE, 3, 2, 1);
        add("rst_check",     0, 1, 0, 0, 0, 0, 0, NONE, 3, 2, 1);
        add("rst_fetch1",    0, 1, 0, 0, 0, 0, 0, B_PR, 3, 3, 1);
        add("rst_fetch2",    0, 1, 0, 0, 0, 0, 0, B_PR, 3, 3, 1);
        add("rst_fetch3",    1, 1, 0, 0, 0, 0, 0, B_PR, 3, 3, 1);
        add("rst_after",     0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("rst_wait",  0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        add("rst_late_resp", 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0);
        add("rst_quiet",     0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);
        // 17 hits: counter reaches 15 after 15 hits and then stays there.
        for (int i = 0; i < 17; i++) begin
            add("sat_idle",  0, 1, 0, 0, 0, 0, 0, NONE, (i < 15) ? i : 15, 0, 0);
            add("sat_check", 0, 1, 0, 1, 0, 0, 0, RHIT, (i < 15) ? i : 15, 0, 0);
        end
        add("sat_done",      0, 0, 0, 0, 0, 0, 0, NONE, 15, 0, 0);
        // Clear together with a hit: clear wins, FSM still completes.
        add("clr_idle",      0, 1, 0, 0, 0, 0, 0, NONE, 15, 0, 0);
        add("clr_check",     0, 1, 0, 1, 0, 0, 1, RHIT, 15, 0, 0);
        add("clr_done",      0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0);

        // Initial reset held for two edges.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        foreach (vq[i]) apply(vq[i]);

        // Hand sequence: clean miss whose fetch sees stat_clr, FSM keeps going.
        begin
            vec_t v;
            v = '{"hs_idle", 0, 1, 0, 0, 0, 0, 0, NONE, 0, 0, 0};   apply(v);
            v = '{"hs_check", 0, 1, 0, 0, 0, 0, 0, NONE, 0, 0, 0};  apply(v);
            v = '{"hs_fetch_clr", 0, 1, 0, 0, 0, 0, 1, B_PR, 0, 1, 0}; apply(v);
            v = '{"hs_fill", 0, 1, 0, 0, 0, 1, 0, FILL, 0, 0, 0};  apply(v);
            v = '{"hs_recheck", 0, 1, 0, 1, 0, 0, 0, RHIT, 0, 0, 0}; apply(v);
            v = '{"hs_done", 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0};  apply(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
